// File: rtl/sram_port_ctrl_if.sv
// Write/read request and read response channels
// between a client and the SRAM port controller.
interface sram_port_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 192,
  parameter int SEGS   = 8
);
  logic              w_req_valid;
  logic              w_req_ready;
  logic [ADDR_W-1:0] w_req_addr;
  logic [DATA_W-1:0] w_req_data;
  logic [SEGS-1:0]   w_req_mask;

  logic              r_req_valid;
  logic              r_req_ready;
  logic [ADDR_W-1:0] r_req_addr;

  logic              r_resp_valid;
  logic              r_resp_ready;
  logic [DATA_W-1:0] r_resp_data;

  modport master (
    output w_req_valid, w_req_addr,
    output w_req_data, w_req_mask,
    input  w_req_ready,
    output r_req_valid, r_req_addr,
    input  r_req_ready,
    input  r_resp_valid, r_resp_data,
    output r_resp_ready
  );

  modport slave (
    input  w_req_valid, w_req_addr,
    input  w_req_data, w_req_mask,
    output w_req_ready,
    input  r_req_valid, r_req_addr,
    output r_req_ready,
    output r_resp_valid, r_resp_data,
    input  r_resp_ready
  );
endinterface

// File: rtl/sram_port_ctrl.sv
// Single-port masked SRAM initiator: zero-fill sweep,
// write/read arbitration and a 2-entry read response FIFO.
module sram_port_ctrl #(
  parameter int DEPTH         = 256,
  parameter int ADDR_W        = 8,
  parameter int DATA_W        = 192,
  parameter int SEGS          = 8,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_done,
  sram_port_ctrl_if.slave   bus,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [SEGS-1:0]   sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic              last_rd, last_rd_nxt;
  logic              inflight, inflight_nxt;
  logic              grant_rd, grant_wr;

  logic [DATA_W-1:0] fifo_mem [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        count;
  logic              resp_valid;
  logic              pop;
  logic [2:0]        credit;
  logic              credit_ok;
  logic              rd_ok;

  assign resp_valid = !reset && (count != 2'd0);
  assign pop        = resp_valid && bus.r_resp_ready;

  // A read may issue only if its data will find a FIFO slot,
  // counting the read already in the SRAM pipe.
  assign credit    = 3'(count) + 3'(inflight) - 3'(pop);
  assign credit_ok = credit < 3'd2;
  assign rd_ok     = bus.r_req_valid && credit_ok;

  assign bus.r_resp_valid = resp_valid;
  assign bus.r_resp_data  = fifo_mem[rd_ptr];
  assign init_done        = !reset && (state == S_RUN);

  // Control state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= INIT_ON_RESET ? S_INIT : S_RUN;
      ptr      <= '0;
      last_rd  <= 1'b0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      last_rd  <= last_rd_nxt;
      inflight <= inflight_nxt;
    end
  end

  // Sweep, arbitration and SRAM command generation.
  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    last_rd_nxt     = last_rd;
    inflight_nxt    = 1'b0;
    grant_rd        = 1'b0;
    grant_wr        = 1'b0;
    sram_en         = 1'b0;
    sram_wmode      = 1'b0;
    sram_addr       = '0;
    sram_wmask      = '0;
    sram_wdata      = '0;
    bus.w_req_ready = 1'b0;
    bus.r_req_ready = 1'b0;
    if (!reset) begin
      unique case (state)
        S_INIT: begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = ptr;
          sram_wmask = '1;
          if (ptr == LAST) begin
            state_nxt = S_RUN;
          end else begin
            ptr_nxt = ptr + ADDR_W'(1);
          end
        end
        S_RUN: begin
          // On conflict the channel not served last wins.
          grant_rd = rd_ok &&
                     (!bus.w_req_valid || !last_rd);
          grant_wr = bus.w_req_valid && !grant_rd;
          unique case (1'b1)
            grant_rd: begin
              sram_en         = 1'b1;
              sram_addr       = bus.r_req_addr;
              bus.r_req_ready = 1'b1;
              inflight_nxt    = 1'b1;
              last_rd_nxt     = 1'b1;
            end
            grant_wr: begin
              sram_en         = 1'b1;
              sram_wmode      = 1'b1;
              sram_addr       = bus.w_req_addr;
              sram_wmask      = bus.w_req_mask;
              sram_wdata      = bus.w_req_data;
              bus.w_req_ready = 1'b1;
              last_rd_nxt     = 1'b0;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Response FIFO: capture read data one cycle after issue.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (inflight) begin
        fifo_mem[wr_ptr] <= sram_rdata;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(inflight) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Directed bench for sram_port_ctrl with a
// behavioural masked SRAM macro attached.
module tb_sram_port_ctrl;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 192;
  localparam int SEGS   = 8;
  localparam int SEG_W  = DATA_W / SEGS;

  logic              clock = 1'b0;
  logic              reset;
  logic              init_done;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [SEGS-1:0]   sram_wmask;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;

  int total = 0;
  int bad   = 0;

  logic [DATA_W-1:0] resp_q [$];
  logic [DATA_W-1:0] mem [DEPTH];

  always #5 clock = ~clock;

  sram_port_ctrl_if #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .SEGS(SEGS)
  ) bus ();

  sram_port_ctrl #(
    .DEPTH(DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .SEGS(SEGS),
    .INIT_ON_RESET(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .init_done(init_done),
    .bus(bus.slave),
    .sram_en(sram_en),
    .sram_wmode(sram_wmode),
    .sram_addr(sram_addr),
    .sram_wmask(sram_wmask),
    .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  // SRAM macro: masked write, 1-cycle read latency.
  always @(posedge clock) begin
    if (sram_en && sram_wmode) begin
      for (int s = 0; s < SEGS; s++) begin
        if (sram_wmask[s]) begin
          mem[sram_addr][s*SEG_W +: SEG_W] <=
            sram_wdata[s*SEG_W +: SEG_W];
        end
      end
    end
    if (sram_en && !sram_wmode) begin
      sram_rdata <= mem[sram_addr];
    end
  end

  // Collect every accepted response.
  always @(negedge clock) begin
    if (bus.r_resp_valid && bus.r_resp_ready) begin
      resp_q.push_back(bus.r_resp_data);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  function automatic logic [DATA_W-1:0] pat(
    input logic [7:0] a
  );
    pat = {24{a ^ 8'h3C}};
  endfunction

  task automatic chk(
    input string        tag,
    input logic [255:0] got,
    input logic [255:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(
    input logic [7:0]        a,
    input logic [DATA_W-1:0] d,
    input logic [7:0]        m
  );
    int n;
    n = 0;
    bus.w_req_valid = 1'b1;
    bus.w_req_addr  = a;
    bus.w_req_data  = d;
    bus.w_req_mask  = m;
    #1;
    while (bus.w_req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("wr_acc", bus.w_req_ready, 1);
    chk("wr_cmd",
        {sram_en, sram_wmode, sram_addr,
         sram_wmask, sram_wdata},
        {1'b1, 1'b1, a, m, d});
    tick();
    bus.w_req_valid = 1'b0;
  endtask

  task automatic rd(
    input string             tag,
    input logic [7:0]        a,
    input logic [DATA_W-1:0] exp
  );
    int n;
    n = 0;
    resp_q.delete();
    bus.r_req_valid = 1'b1;
    bus.r_req_addr  = a;
    #1;
    while (bus.r_req_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_acc"}, bus.r_req_ready, 1);
    tick();
    bus.r_req_valid = 1'b0;
    n = 0;
    while (resp_q.size() == 0 && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_got"}, resp_q.size() != 0, 1);
    if (resp_q.size() != 0) begin
      chk(tag, resp_q.pop_front(), exp);
    end
  endtask

  initial begin
    int nr;
    int nw;

    reset            = 1'b1;
    bus.w_req_valid  = 1'b1;
    bus.w_req_addr   = '0;
    bus.w_req_data   = '0;
    bus.w_req_mask   = '0;
    bus.r_req_valid  = 1'b1;
    bus.r_req_addr   = '0;
    bus.r_resp_ready = 1'b1;
    tick();
    tick();

    // 1: reset outputs, init sweep, read zero
    chk("rst_out",
        {init_done, sram_en, sram_wmode, sram_addr,
         sram_wmask, sram_wdata, bus.w_req_ready,
         bus.r_req_ready, bus.r_resp_valid}, 0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("init",
          {init_done, sram_en, sram_wmode, sram_addr,
           sram_wmask, sram_wdata, bus.w_req_ready,
           bus.r_req_ready},
          {1'b0, 1'b1, 1'b1, 8'(i), 8'hFF,
           192'h0, 1'b0, 1'b0});
      if (i == DEPTH - 1) begin
        bus.w_req_valid = 1'b0;
        bus.r_req_valid = 1'b0;
      end
      tick();
    end
    chk("run_idle",
        {init_done, sram_en, sram_wmode, sram_addr,
         sram_wmask, sram_wdata},
        {1'b1, 210'h0});
    rd("rd_zero", 8'h10, '0);

    // 2: masked write, then zero-mask write
    wr(8'h05, {8{24'hA5A5A5}}, 8'h0F);
    rd("mask_lo", 8'h05, {96'h0, {4{24'hA5A5A5}}});
    wr(8'h05, '1, 8'h00);
    rd("mask_zero", 8'h05, {96'h0, {4{24'hA5A5A5}}});
    wr(8'h20, pat(8'h20), 8'hFF);
    for (int i = 0; i < 3; i++) begin
      wr(8'(8'h40 + i), pat(8'(8'h40 + i)), 8'hFF);
    end
    for (int i = 0; i < 16; i++) begin
      wr(8'(8'h50 + i), pat(8'(8'h50 + i)), 8'hFF);
    end

    // 3: conflicts alternate, read first
    resp_q.delete();
    nr = 0;
    nw = 0;
    bus.r_req_addr  = 8'h20;
    bus.w_req_addr  = 8'h30;
    bus.w_req_data  = pat(8'h30);
    bus.w_req_mask  = 8'hFF;
    bus.r_req_valid = 1'b1;
    bus.w_req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("arb",
          {sram_en, sram_wmode,
           bus.r_req_ready, bus.w_req_ready},
          (i % 2 == 0) ? 4'b1010 : 4'b1101);
      if (bus.r_req_ready) nr++;
      if (bus.w_req_ready) nw++;
      tick();
    end
    bus.r_req_valid = 1'b0;
    bus.w_req_valid = 1'b0;
    chk("arb_nr", nr, 4);
    chk("arb_nw", nw, 4);
    repeat (5) tick();
    chk("arb_resp_n", resp_q.size(), 4);
    while (resp_q.size() != 0) begin
      chk("arb_data", resp_q.pop_front(), pat(8'h20));
    end
    rd("arb_wr", 8'h30, pat(8'h30));

    // 4: backpressure limits to 2 outstanding
    resp_q.delete();
    bus.r_resp_ready = 1'b0;
    bus.r_req_valid  = 1'b1;
    bus.r_req_addr   = 8'h40;
    #1;
    chk("bp_a0", bus.r_req_ready, 1);
    tick();
    bus.r_req_addr = 8'h41;
    #1;
    chk("bp_a1", bus.r_req_ready, 1);
    tick();
    bus.r_req_addr = 8'h42;
    #1;
    chk("bp_a2_blk", bus.r_req_ready, 0);
    tick();
    #1;
    chk("bp_full",
        {bus.r_req_ready, bus.r_resp_valid,
         bus.r_resp_data},
        {1'b0, 1'b1, pat(8'h40)});
    bus.r_resp_ready = 1'b1;
    #1;
    chk("bp_resume", bus.r_req_ready, 1);
    tick();
    bus.r_req_valid = 1'b0;
    repeat (5) tick();
    chk("bp_resp_n", resp_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (resp_q.size() != 0) begin
        chk("bp_order", resp_q.pop_front(),
            pat(8'(8'h40 + i)));
      end
    end

    // 5: streaming reads at full rate
    resp_q.delete();
    for (int i = 0; i < 16; i++) begin
      bus.r_req_valid = 1'b1;
      bus.r_req_addr  = 8'(8'h50 + i);
      #1;
      chk("st_rdy", bus.r_req_ready, 1);
      chk("st_vld", bus.r_resp_valid, i >= 2);
      tick();
    end
    bus.r_req_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("st_tail", bus.r_resp_valid, 1);
      tick();
    end
    #1;
    chk("st_end", bus.r_resp_valid, 0);
    repeat (2) tick();
    chk("st_resp_n", resp_q.size(), 16);
    for (int i = 0; i < 16; i++) begin
      if (resp_q.size() != 0) begin
        chk("st_data", resp_q.pop_front(),
            pat(8'(8'h50 + i)));
      end
    end

    // 6: reset with buffered responses
    bus.r_resp_ready = 1'b0;
    bus.r_req_valid  = 1'b1;
    bus.r_req_addr   = 8'h50;
    tick();
    bus.r_req_addr = 8'h51;
    tick();
    bus.r_req_valid = 1'b0;
    tick();
    #1;
    chk("rs_buf", bus.r_resp_valid, 1);
    resp_q.delete();
    reset = 1'b1;
    #1;
    chk("rs_hold",
        {bus.r_resp_valid, sram_en, init_done,
         bus.r_req_ready, bus.w_req_ready}, 0);
    tick();
    reset            = 1'b0;
    bus.r_resp_ready = 1'b1;
    #1;
    chk("rs_sweep0",
        {bus.r_resp_valid, sram_en, sram_wmode,
         sram_addr, init_done},
        {1'b0, 1'b1, 1'b1, 8'h00, 1'b0});
    tick();
    chk("rs_sweep1",
        {bus.r_resp_valid, sram_en, sram_addr},
        {1'b0, 1'b1, 8'h01});
    repeat (DEPTH - 1) tick();
    chk("rs_done", init_done, 1);
    chk("rs_no_resp", resp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
